// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan decoder.
// Build option PS2_ASCII_EN adds an ASCII field to events and the lookup function.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        PAUSE   = 3'd4
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef struct packed {
`ifdef PS2_ASCII_EN
        logic [7:0] ascii;
`endif
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

    // Keyboard-to-host controller responses, never key data.
    function automatic logic is_response(input logic [7:0] code);
        return (code == 8'hFA) || (code == 8'hAA) || (code == 8'hEE) ||
               (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

`ifdef PS2_ASCII_EN
    function automatic logic [7:0] ps2_ascii(input logic [7:0] code, input logic shifted);
        logic [7:0] letter;
        logic [7:0] other;
        letter = 8'h00;
        other  = 8'h00;
        case (code)
            8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
            8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
            8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
            default: letter = 8'h00;
        endcase
        case (code)
            8'h16: other = shifted ? 8'h00 : 8'h31;
            8'h1E: other = shifted ? 8'h00 : 8'h32;
            8'h26: other = shifted ? 8'h00 : 8'h33;
            8'h25: other = shifted ? 8'h00 : 8'h34;
            8'h2E: other = shifted ? 8'h00 : 8'h35;
            8'h36: other = shifted ? 8'h00 : 8'h36;
            8'h3D: other = shifted ? 8'h00 : 8'h37;
            8'h3E: other = shifted ? 8'h00 : 8'h38;
            8'h46: other = shifted ? 8'h00 : 8'h39;
            8'h45: other = shifted ? 8'h00 : 8'h30;
            8'h29: other = 8'h20;
            8'h5A: other = 8'h0D;
            8'h66: other = 8'h08;
            default: other = 8'h00;
        endcase
        if (letter != 8'h00) begin
            return shifted ? (letter - 8'h20) : letter;
        end
        return other;
    endfunction
`endif

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Byte-stream input and key-event valid/ready output of the scan decoder.
// master = decoder side, slave = byte source plus event consumer.
interface ps2_scan_decoder_if;
    logic [7:0] ps2_code;
    logic       ps2_code_new;
    logic       key_ready;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [7:0] key_ascii;
    logic       overflow;

    modport master (
        input  ps2_code, ps2_code_new, key_ready,
        output key_valid, key_code, key_ext, key_break, key_ascii, overflow
    );

    modport slave (
        output ps2_code, ps2_code_new, key_ready,
        input  key_valid, key_code, key_ext, key_break, key_ascii, overflow
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// Generic first-word fall-through FIFO with full/empty flags.
// Latency: a write is visible on dout after the writing edge.
// Backpressure: writes while full are ignored unless a read happens in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_scan_decoder.sv
// Folds Set-2 E0/F0/E1 prefix sequences into key events; PS2_ASCII_EN adds shift tracking and ASCII.
// Latency: event visible on key_valid one edge after its final byte when the FIFO is empty.
// Backpressure: key_ready pops the FIFO head; events arriving while full are dropped and flag overflow.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    ps2_scan_decoder_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = $bits(ps2_evt_t);

    ps2_state_e    state_q, state_d;
    logic [2:0]    pause_q, pause_d;
    logic [TW-1:0] tmo_cnt;
    logic          new_q;
    logic          byte_vld;
    logic [7:0]    byte_dat;
    logic          tmo_hit;
    logic          push;
    ps2_evt_t      evt;
    ps2_evt_t      head;
    logic [EW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          ovf_q;

    assign byte_vld = bus.ps2_code_new && !new_q;
    assign byte_dat = bus.ps2_code;
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES));

`ifdef PS2_ASCII_EN
    logic lshift_q;
    logic rshift_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
        end else if (push && !evt.ext) begin
            if (evt.code == PS2_LSHIFT) lshift_q <= !evt.brk;
            if (evt.code == PS2_RSHIFT) rshift_q <= !evt.brk;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        pause_d  = pause_q;
        push     = 1'b0;
        evt      = '0;
        evt.code = byte_dat;
        if (byte_vld) begin
            case (state_q)
                IDLE: begin
                    if (byte_dat == PS2_EXT) begin
                        state_d = EXT;
                    end else if (byte_dat == PS2_BRK) begin
                        state_d = BRK;
                    end else if (byte_dat == PS2_PAUSE) begin
                        state_d = PAUSE;
                        pause_d = 3'd7;
                    end else if (!is_response(byte_dat)) begin
                        push = 1'b1;
                    end
                end
                EXT: begin
                    if (byte_dat == PS2_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                        push    = (byte_dat != PS2_LSHIFT);
                        evt.ext = 1'b1;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    push    = 1'b1;
                    evt.brk = 1'b1;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    push    = (byte_dat != PS2_LSHIFT);
                    evt.ext = 1'b1;
                    evt.brk = 1'b1;
                end
                PAUSE: begin
                    pause_d = pause_q - 3'd1;
                    if (pause_q == 3'd1) begin
                        state_d  = IDLE;
                        push     = 1'b1;
                        evt.code = PS2_PAUSE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_hit) begin
            state_d = IDLE;
        end
`ifdef PS2_ASCII_EN
        evt.ascii = (evt.ext || evt.brk) ? 8'h00 : ps2_ascii(evt.code, lshift_q || rshift_q);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pause_q <= 3'd0;
            new_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
            new_q   <= bus.ps2_code_new;
            // Counts silent cycles inside a prefix; any accepted byte restarts it.
            if (state_q == IDLE || byte_vld) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    assign pop = bus.key_valid && bus.key_ready;

    ps2_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (evt),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign head          = ps2_evt_t'(fifo_dout);
    assign bus.key_valid = !fifo_empty;
    assign bus.key_code  = head.code;
    assign bus.key_ext   = head.ext;
    assign bus.key_break = head.brk;
    assign bus.overflow  = ovf_q;
`ifdef PS2_ASCII_EN
    assign bus.key_ascii = head.ascii;
`else
    assign bus.key_ascii = 8'h00;
`endif
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder; also valid with PS2_ASCII_EN defined.
module tb_ps2_scan_decoder;
    localparam int TMO = 40;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    ps2_scan_decoder_if bus();

    ps2_scan_decoder #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic e, input logic b);
`ifdef PS2_ASCII_EN
        if (e || b) return 8'h00;
        case (c)
            8'h1C: return 8'h61;
            8'h1B: return 8'h73;
            8'h15: return 8'h71;
            8'h16: return 8'h31;
            8'h29: return 8'h20;
            default: return 8'h00;
        endcase
`else
        return 8'h00;
`endif
    endfunction

    task automatic expect_evt(input logic [7:0] c, input logic e, input logic b);
        exp_t x;
        x = {c, e, b, model_ascii(c, e, b)};
        sb.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.ps2_code     = b;
        bus.ps2_code_new = 1'b1;
        @(negedge clk);
        bus.ps2_code_new = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && bus.key_valid; i++) @(negedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: every handshake the DUT completes is compared with the oldest expected event.
    initial begin
        exp_t got;
        exp_t want;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && bus.key_valid && bus.key_ready) begin
                got = {bus.key_code, bus.key_ext, bus.key_break, bus.key_ascii};
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL event_unexpected: got %h, none expected", got);
                end else begin
                    want = sb.pop_front();
                    if (got !== want) $display("FAIL event_order: got %h, required %h", got, want);
                    else n_pass++;
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        bus.ps2_code = 8'h00;
        bus.ps2_code_new = 1'b0;
        bus.key_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.key_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", bus.key_valid);
        else n_pass++;
        n_checks++;
        if ({bus.key_code, bus.key_ext, bus.key_break, bus.key_ascii} !== 18'h0)
            $display("FAIL reset_key: got %h %b %b %h, required zeros", bus.key_code, bus.key_ext, bus.key_break, bus.key_ascii);
        else n_pass++;
        n_checks++;
        if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b, required 0", bus.overflow);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_make_break();
        bus.key_ready = 1'b0;
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b0);
        n_checks++;
        if (bus.key_valid !== 1'b1) $display("FAIL make_latency: valid %b, required 1", bus.key_valid);
        else n_pass++;
        bus.key_ready = 1'b1;
        wait_drain();
        send_byte(8'hF0);
        n_checks++;
        if (bus.key_valid !== 1'b0) $display("FAIL break_prefix_quiet: valid %b, required 0", bus.key_valid);
        else n_pass++;
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b1);
        n_checks++;
        if (bus.key_valid !== 1'b1) $display("FAIL break_latency: valid %b, required 1", bus.key_valid);
        else n_pass++;
        wait_drain();
    endtask

    task automatic test_level_held();
        bus.key_ready = 1'b0;
        @(negedge clk);
        bus.ps2_code = 8'h1B;
        bus.ps2_code_new = 1'b1;
        expect_evt(8'h1B, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        bus.ps2_code_new = 1'b0;
        bus.key_ready = 1'b1;
        wait_drain();
        n_checks++;
        if (sb.size() != 0) $display("FAIL level_held: %0d events missing, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_extended();
        bus.key_ready = 1'b1;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        expect_evt(8'h75, 1'b1, 1'b1);
        n_checks++;
        if (bus.key_valid !== 1'b1) $display("FAIL ext_break_latency: valid %b, required 1", bus.key_valid);
        else n_pass++;
        wait_drain();
        send_byte(8'hE0);
        send_byte(8'h12);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.key_valid !== 1'b0) $display("FAIL fake_shift: valid %b, required 0", bus.key_valid);
        else n_pass++;
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b0);
        wait_drain();
    endtask

    task automatic test_pause();
        logic [7:0] seq [7];
        bus.key_ready = 1'b1;
        seq = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        send_byte(8'hE1);
        for (int i = 0; i < 6; i++) send_byte(seq[i]);
        n_checks++;
        if (bus.key_valid !== 1'b0) $display("FAIL pause_early: valid %b, required 0", bus.key_valid);
        else n_pass++;
        send_byte(seq[6]);
        expect_evt(8'hE1, 1'b0, 1'b0);
        n_checks++;
        if (bus.key_valid !== 1'b1) $display("FAIL pause_event: valid %b, required 1", bus.key_valid);
        else n_pass++;
        wait_drain();
        send_byte(8'hFA);
        n_checks++;
        if (bus.key_valid !== 1'b0) $display("FAIL response_discard: valid %b, required 0", bus.key_valid);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bus.key_ready = 1'b1;
        send_byte(8'hE0);
        repeat (TMO - 5) @(negedge clk);
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b1, 1'b0);
        wait_drain();
        send_byte(8'hE0);
        repeat (TMO + 5) @(negedge clk);
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b0);
        wait_drain();
        n_checks++;
        if (sb.size() != 0) $display("FAIL timeout_events: %0d outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h1C, 8'h1B, 8'h15, 8'h16, 8'h29};
        bus.key_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(codes[i]);
            expect_evt(codes[i], 1'b0, 1'b0);
        end
        n_checks++;
        if (bus.overflow !== 1'b0) $display("FAIL overflow_early: got %b, required 0", bus.overflow);
        else n_pass++;
        send_byte(codes[4]);
        n_checks++;
        if (bus.overflow !== 1'b1) $display("FAIL overflow_set: got %b, required 1", bus.overflow);
        else n_pass++;
        bus.key_ready = 1'b1;
        wait_drain();
        n_checks++;
        if (bus.key_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL overflow_drain: valid %b outstanding %0d, required 0 0", bus.key_valid, sb.size());
        else n_pass++;
        n_checks++;
        if (bus.overflow !== 1'b1) $display("FAIL overflow_sticky: got %b, required 1", bus.overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.key_ready = 1'b0;
        send_byte(8'h1C);
        send_byte(8'h1B);
        send_byte(8'hF0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.key_valid !== 1'b0 || bus.overflow !== 1'b0)
            $display("FAIL reset_mid: valid %b overflow %b, required 0 0", bus.key_valid, bus.overflow);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        bus.key_ready = 1'b1;
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b0);
        n_checks++;
        if (bus.key_valid !== 1'b1 || bus.key_break !== 1'b0)
            $display("FAIL reset_mid_next: valid %b break %b, required 1 0", bus.key_valid, bus.key_break);
        else n_pass++;
        wait_drain();
    endtask

    task automatic test_full_pop();
        logic [7:0] codes [4];
        codes = '{8'h15, 8'h16, 8'h1C, 8'h1B};
        bus.key_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(codes[i]);
            expect_evt(codes[i], 1'b0, 1'b0);
        end
        // Fifth push lands in the same cycle as the first pop.
        @(negedge clk);
        bus.ps2_code = 8'h29;
        bus.ps2_code_new = 1'b1;
        bus.key_ready = 1'b1;
        expect_evt(8'h29, 1'b0, 1'b0);
        @(negedge clk);
        bus.ps2_code_new = 1'b0;
        wait_drain();
        n_checks++;
        if (bus.overflow !== 1'b0 || sb.size() != 0)
            $display("FAIL full_pop: overflow %b outstanding %0d, required 0 0", bus.overflow, sb.size());
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_make_break();
        test_level_held();
        test_extended();
        test_pause();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_full_pop();
        n_checks++;
        if (sb.size() != 0) $display("FAIL final_scoreboard: %0d outstanding, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Downstream consumer of the PS/2 receiver's byte stream (`ps2_code` / `ps2_code_new`). It turns raw Set-2 scan bytes into whole key events, folding the E0 (extended), F0 (break) and E1 (pause) prefix sequences. Events are buffered in a small FIFO and presented on a valid/ready interface to whatever drives LEDs, a display or a CPU bus.

## Interface
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of two, at least 2.
- `TIMEOUT_CYCLES`, 1_000_000: idle `clk` cycles allowed inside a prefix sequence before it is abandoned (20 ms at 50 MHz).

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  system clock, same domain as the PS/2 receiver.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_code`  in  8  byte from the receiver.
- `ps2_code_new`  in  1  byte-available flag; only its rising edge is used.
- `key_ready`  in  1  consumer accepts the head event.
- `key_valid`  out  1  FIFO not empty.
- `key_code`  out  8  final scan byte of the head event (E1 for pause).
- `key_ext`  out  1  head event had an E0 prefix.
- `key_break`  out  1  head event is a release (F0 seen).
- `key_ascii`  out  8  ASCII of the head event; 0 when there is none.
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- Byte strobe: `ps2_code_new` is registered; a byte is accepted in the cycle where `ps2_code_new`=1 and the registered copy is 0. Level-held and single-cycle-pulse sources both work.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- From IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE with pause count = 7.
  - FA, AA, EE, FE, 00, FF (controller responses) → discarded, stay in IDLE.
  - Any other byte → push {code, ext=0, brk=0}.
- From EXT:
  - F0 → EXT_BRK.
  - 12 (fake shift) → discard, go to IDLE.
  - Other byte → push {code, 1, 0}, go to IDLE.
- From BRK: any byte → push {code, 0, 1}, go to IDLE.
- From EXT_BRK:
  - 12 → discard, go to IDLE.
  - Other byte → push {code, 1, 1}, go to IDLE.
- From PAUSE: each accepted byte decrements the pause count. When it reaches 0, push {E1, 0, 0} and go to IDLE.
- Timeout: a counter runs in any non-IDLE state and clears on each accepted byte. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE with no push. If a byte is accepted in the same cycle, the byte wins.
- FIFO is first-word fall-through; the head drives the `key_*` outputs directly.
  - A pop happens when `key_valid` and `key_ready` are both 1.
  - On a push while full, the new event is dropped and `overflow` is set. If a pop happens in the same cycle, the push is accepted.
  - A push and pop together on an empty FIFO is impossible, because `key_valid`=0.
- `key_ready` while `key_valid`=0 is ignored.

## Timing
- Reset values: FSM in IDLE; FIFO empty; `key_valid`=0; `key_code`, `key_ext`, `key_break`, `key_ascii` = 0; `overflow`=0; counters 0; shift state released.
- Latency: the final byte of a sequence is accepted at edge N. `key_valid` is 1 after edge N when the FIFO was empty. Behind a non-empty FIFO, ordering is preserved.
- A pop at edge M presents the next entry after edge M, or drops `key_valid` if the FIFO is now empty.
- Asserting `reset_n` mid-sequence or with entries queued clears everything immediately. A sequence interrupted by reset is never emitted.
- Throughput: one byte per cycle is supported; the PS/2 receiver is far slower.

## Configuration
- `PS2_ASCII_EN` defined:
  - Tracks shift state from non-extended 12/59 make and break events.
  - Computes ASCII at push time and stores it in the FIFO, so each entry is 18 bits.
  - Map: letters 1C→'a' ('A' when shifted); digits 16,1E,26,25,2E,36,3D,3E,46,45 → '1'..'9','0' (unshifted only); 29→20h; 5A→0Dh; 66→08h.
  - Break events, extended events and all other codes give 0.
- `PS2_ASCII_EN` undefined:
  - No shift logic, no lookup.
  - FIFO entries are 10 bits.
  - `key_ascii` is tied to 0.

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum;
  - the constants `PS2_EXT`=E0, `PS2_BRK`=F0, `PS2_PAUSE`=E1, `PS2_LSHIFT`=12, `PS2_RSHIFT`=59;
  - the event struct type;
  - under `PS2_ASCII_EN`, the ASCII lookup function.
- Sub-module `ps2_event_fifo`: parameterised width and depth, first-word fall-through, with full/empty flags.

## Test plan
- Bytes 1C; then F0,1C → events {1C,0,0} then {1C,0,1}. Each `key_valid` appears one cycle after the final byte; with `PS2_ASCII_EN`, `key_ascii`=61h then 0.
- E0,F0,75 → single event {75,1,1}. E0,12 → no event.
- E1 followed by seven bytes → exactly one event {E1,0,0}. A byte FA in IDLE → no event.
- E0 then silence for `TIMEOUT_CYCLES` → FSM back in IDLE. A following 1C gives {1C,0,0}, not extended.
- `key_ready`=0 with `FIFO_DEPTH`=4 and 5 make codes → 4 queued, `overflow`=1. Then `key_ready`=1 → the 4 events are drained in order and `key_valid`=0 afterwards.
- Pulse `reset_n` low after F0 with 2 events queued → `key_valid`=0 and `overflow`=0 immediately. Next byte 1C → {1C,0,0}, not a break.
